// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed seven-segment scanner.
// One pattern register per digit. Digits are scanned round-robin, each held
// for DIV cycles. Anodes stay off for the first BLANK cycles of every slot so
// the previous digit's pattern never ghosts onto the new anode.
module seg_scan_driver #(
    parameter int N      = 7,
    parameter int DIGITS = 4,
    parameter int DIV    = 100000,
    parameter int DIV_W  = 17,
    parameter int BLANK  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      seg_in,
    input  logic [2:0]        dig_sel,
    input  logic              wr_en,
    input  logic              blank_en,
    output logic [N-1:0]      seg_out,
    output logic [DIGITS-1:0] an_out,
    output logic [2:0]        dig_idx,
    output logic              frame_tick
);

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DIGITS - 1);

    logic [DIV_W-1:0]  cnt;
    logic [2:0]        idx;
    logic [N-1:0]      regs [DIGITS];
    logic [N-1:0]      cur_pat;
    logic [DIGITS-1:0] an_nxt;
    logic              in_gap;
    logic              slot_end;
    logic              frame_end;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign dig_idx   = idx;

    // Blanking gap at the start of each slot; compiled out when BLANK is 0
    // so there is no always-false compare against zero.
    generate
        if (BLANK > 0) begin : g_gap
            assign in_gap = (cnt < DIV_W'(BLANK));
        end else begin : g_nogap
            assign in_gap = 1'b0;
        end
    endgenerate

    // Prescaler and digit index; idx never leaves 0..DIGITS-1, so unused
    // upper bits stay 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame pulse registered on the same edge that wraps idx back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_tick <= 1'b0;
        else     frame_tick <= frame_end;
    end

    // Digit register file; out-of-range dig_sel matches no entry and is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < DIGITS; i++)
                if (wr_en && dig_sel == 3'(i)) regs[i] <= seg_in;
        end
    end

    // Select the pattern of the digit in its slot and decode its anode.
    always_comb begin
        cur_pat = '0;
        an_nxt  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == 3'(i)) begin
                cur_pat = regs[i];
                if (!(blank_en || in_gap)) an_nxt[i] = 1'b0;
            end
        end
    end

    // Registered active-low drive; dark and off while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_out <= '1;
            an_out  <= '1;
        end else begin
            seg_out <= ~cur_pat;
            an_out  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=4, DIV=8, BLANK=2, N=7.
module tb_seg_scan_driver;

    localparam int N      = 7;
    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int DIV_W  = 4;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * DIV;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      seg_in = '0;
    logic [2:0]        dig_sel = '0;
    logic              wr_en = 1'b0;
    logic              blank_en = 1'b0;
    logic [N-1:0]      seg_out;
    logic [DIGITS-1:0] an_out;
    logic [2:0]        dig_idx;
    logic              frame_tick;

    int n_chk  = 0;
    int n_fail = 0;
    int ecount = 0;              // edges since last reset release
    bit seg_on = 1'b0;           // check seg_out against exp_seg
    logic [N-1:0] exp_seg [DIGITS];

    seg_scan_driver #(.N(N), .DIGITS(DIGITS), .DIV(DIV), .DIV_W(DIV_W), .BLANK(BLANK)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel), .wr_en(wr_en),
        .blank_en(blank_en), .seg_out(seg_out), .an_out(an_out), .dig_idx(dig_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, ecount, got, exp);
        end
    endtask

    // Advance one edge, then check the scan outputs against the timing formula.
    task automatic tick();
        logic       bpre;
        logic [3:0] an_x;
        int c, d;
        bpre = blank_en;
        @(posedge clk); #1;
        ecount++;
        c = (ecount - 1) % DIV;
        d = ((ecount - 1) / DIV) % DIGITS;
        an_x = 4'hF;
        if (!bpre && c >= BLANK) an_x[d] = 1'b0;
        check("an_out", 32'(an_out), 32'(an_x));
        check("dig_idx", 32'(dig_idx), 32'((ecount / DIV) % DIGITS));
        check("frame_tick", 32'(frame_tick), 32'(ecount % FRAME == 0));
        if (seg_on) check("seg_out", 32'(seg_out), 32'(exp_seg[d]));
    endtask

    task automatic align(input int phase);
        for (int i = 0; i < FRAME && (ecount % FRAME) != phase; i++) tick();
    endtask

    task automatic write(input logic [2:0] sel, input logic [N-1:0] val);
        wr_en = 1'b1; dig_sel = sel; seg_in = val;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DIGITS; i++) exp_seg[i] = 7'h7F;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", 32'(an_out), 32'hF);
        check("rst_seg", 32'(seg_out), 32'h7F);
        check("rst_tick", 32'(frame_tick), 32'h0);
        check("rst_idx", 32'(dig_idx), 32'h0);

        // 1: idle scan after release, registers all zero -> dark segments
        @(posedge clk); #1;
        rst = 1'b0; ecount = 0; seg_on = 1'b1;
        repeat (FRAME + 8) tick();

        // 2: load all four digits, then check a full frame
        seg_on = 1'b0;
        write(3'd0, 7'h3F);
        write(3'd1, 7'h06);
        write(3'd2, 7'h5B);
        write(3'd3, 7'h4F);
        exp_seg[0] = 7'h40; exp_seg[1] = 7'h79; exp_seg[2] = 7'h24; exp_seg[3] = 7'h30;
        align(0);
        seg_on = 1'b1;
        repeat (FRAME) tick();

        // 3: overwrite digit 0 while it is displayed (cnt=3)
        align(3);
        seg_on = 1'b0;
        write(3'd0, 7'h7F);
        check("wr_e_seg", 32'(seg_out), 32'h40);
        check("wr_e_an", 32'(an_out), 32'hE);
        tick();
        check("wr_e1_seg", 32'(seg_out), 32'h00);
        check("wr_e1_an", 32'(an_out), 32'hE);
        exp_seg[0] = 7'h00;
        seg_on = 1'b1;

        // 4: out-of-range writes held for a whole frame change nothing
        align(0);
        wr_en = 1'b1; dig_sel = 3'd5; seg_in = 7'h7F;
        repeat (FRAME) tick();
        wr_en = 1'b0;
        repeat (4) tick();

        // 5: blank_en for 12 cycles spanning a slot boundary and a frame wrap
        align(26);
        blank_en = 1'b1;
        repeat (12) tick();
        blank_en = 1'b0;
        repeat (FRAME + 4) tick();

        // 6: async reset at dig_idx=2, cnt=5
        align(21);
        check("pre_rst_an", 32'(an_out), 32'hB);
        check("pre_rst_seg", 32'(seg_out), 32'h24);
        rst = 1'b1;
        #1;
        check("arst_an", 32'(an_out), 32'hF);
        check("arst_seg", 32'(seg_out), 32'h7F);
        check("arst_idx", 32'(dig_idx), 32'h0);
        check("arst_tick", 32'(frame_tick), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; ecount = 0;
        for (int i = 0; i < DIGITS; i++) exp_seg[i] = 7'h7F;
        repeat (FRAME + 2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
